// File: rtl/logic_unit_pipe_pkg.sv
// logic_unit_defs: shared definitions for the pipelined bitwise logic unit.
//   OP_W             width of the operation select field
//   OP_AND..OP_PASS  3-bit operation codes
//   op_bit()         single-bit evaluation of any operation code
package logic_unit_defs;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_NAND = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    // One bit of the logic unit; every 3-bit code maps to a defined value.
    function automatic logic op_bit(input logic [OP_W-1:0] op,
                                    input logic a,
                                    input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            OP_PASS: r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand input channel and result output channel.
//   in_valid/in_ready/op/R2/R3          producer -> unit (valid/ready)
//   out_valid/out_ready/result/flag_*   unit -> consumer (valid/ready)
// Modports: master = producer/consumer side, slave = the logic unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    import logic_unit_defs::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_ones;
    logic             flag_parity;

    modport master (
        output in_valid, op, R2, R3, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
    );

    modport slave (
        input  in_valid, op, R2, R3, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
    );

endinterface

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational WIDTH-bit operation select plus flags.
//   op           operation code
//   a, b         operands (b ignored for NOT / PASS)
//   result       bitwise result
//   flag_zero    result is all zeros
//   flag_ones    result is all ones
//   flag_parity  XOR-reduction of result
module logic_unit_core
    import logic_unit_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_parity
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign result[gi] = op_bit(op, a[gi], b[gi]);
        end
    endgenerate

    assign flag_zero   = ~|result;
    assign flag_ones   = &result;
    assign flag_parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined bitwise logic unit.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        slave side of logic_unit_pipe_if (operands in, result out)
//   count_clr  synchronous clear of op_count (wins over an increment)
//   op_count   saturating count of output handshakes
// Stage A captures operands; stage B evaluates and registers result/flags.
module logic_unit_pipe
    import logic_unit_defs::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_pipe_if.slave    bus,
    input  logic                count_clr,
    output logic [COUNT_W-1:0]  op_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Stage A
    logic             a_valid_reg;
    logic [OP_W-1:0]  a_op_reg;
    logic [WIDTH-1:0] a_r2_reg;
    logic [WIDTH-1:0] a_r3_reg;

    // Stage B
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             flag_zero_reg;
    logic             flag_ones_reg;
    logic             flag_parity_reg;

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;

    logic             a_ready;
    logic             b_ready;
    logic             out_hs;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_ones;
    logic             core_parity;

    // in_ready depends combinationally on out_ready so a full pipe can
    // accept and emit in the same cycle without a bubble.
    assign b_ready      = ~out_valid_reg | bus.out_ready;
    assign a_ready      = ~a_valid_reg | b_ready;
    assign bus.in_ready = a_ready;
    assign out_hs       = out_valid_reg & bus.out_ready;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op          (a_op_reg),
        .a           (a_r2_reg),
        .b           (a_r3_reg),
        .result      (core_result),
        .flag_zero   (core_zero),
        .flag_ones   (core_ones),
        .flag_parity (core_parity)
    );

    always_comb begin
        count_next = count_reg;
        if (count_clr) begin
            count_next = '0;
        end else if (out_hs && (count_reg != COUNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_reg     <= 1'b0;
            a_op_reg        <= '0;
            a_r2_reg        <= '0;
            a_r3_reg        <= '0;
            out_valid_reg   <= 1'b0;
            result_reg      <= '0;
            flag_zero_reg   <= 1'b0;
            flag_ones_reg   <= 1'b0;
            flag_parity_reg <= 1'b0;
            count_reg       <= '0;
        end else begin
            // When stage A can move, it either takes new input or empties.
            if (a_ready) begin
                a_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    a_op_reg <= bus.op;
                    a_r2_reg <= bus.R2;
                    a_r3_reg <= bus.R3;
                end
            end
            if (b_ready) begin
                out_valid_reg <= a_valid_reg;
                if (a_valid_reg) begin
                    result_reg      <= core_result;
                    flag_zero_reg   <= core_zero;
                    flag_ones_reg   <= core_ones;
                    flag_parity_reg <= core_parity;
                end
            end
            count_reg <= count_next;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.result      = result_reg;
    assign bus.flag_zero   = flag_zero_reg;
    assign bus.flag_ones   = flag_ones_reg;
    assign bus.flag_parity = flag_parity_reg;
    assign op_count        = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe
// with WIDTH=8, COUNT_W=4. Inputs change and outputs are sampled around
// the falling clock edge.
module tb_logic_unit_pipe;
    import logic_unit_defs::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       count_clr = 1'b0;
    logic [3:0] op_count;

    int total  = 0;
    int passed = 0;

    logic_unit_pipe_if #(.WIDTH(8)) bus ();

    logic_unit_pipe #(
        .WIDTH   (8),
        .COUNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .count_clr (count_clr),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = OP_AND;
        bus.R2 = 8'h00;
        bus.R3 = 8'h00;
        bus.out_ready = 1'b1;
        count_clr = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_during got=%b exp=1", bus.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 8'h00) $display("FAIL reset_result got=%h exp=00", bus.result);
        else passed++;
        total++;
        if ({bus.flag_zero, bus.flag_ones, bus.flag_parity} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {bus.flag_zero, bus.flag_ones, bus.flag_parity});
        else passed++;
        total++;
        if (op_count !== 4'd0) $display("FAIL reset_op_count got=%0d exp=0", op_count);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_after got=%b exp=1", bus.in_ready);
        else passed++;
        $display("tx reset done");
        rst_n = 1'b1;
    endtask

    task automatic test_ops();
        logic [7:0] exp_res [8];
        exp_res = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = 1'b1;
            bus.op        = 3'(i);
            bus.R2        = 8'hA5;
            bus.R3        = 8'h0F;
            bus.out_ready = 1'b1;
            #1;
            total++;
            if (bus.in_ready !== 1'b1) $display("FAIL ops_in_ready op=%0d got=%b exp=1", i, bus.in_ready);
            else passed++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== 1'b0) $display("FAIL ops_early_valid op=%0d got=%b exp=0", i, bus.out_valid);
            else passed++;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== exp_res[i])
                $display("FAIL ops_result op=%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.result, exp_res[i]);
            else passed++;
            total++;
            if ({bus.flag_zero, bus.flag_ones, bus.flag_parity} !== 3'b000)
                $display("FAIL ops_flags op=%0d got=%b exp=000", i, {bus.flag_zero, bus.flag_ones, bus.flag_parity});
            else passed++;
            $display("tx op=%0d R2=a5 R3=0f result=%h", i, bus.result);
        end
    endtask

    task automatic test_flags();
        logic [2:0] v_op   [5];
        logic [7:0] v_a    [5];
        logic [7:0] v_b    [5];
        logic [7:0] v_res  [5];
        logic [2:0] v_flag [5];
        v_op   = '{OP_AND, OP_XNOR, OP_PASS, OP_XOR, OP_NOT};
        v_a    = '{8'hF0, 8'h3C, 8'h01, 8'h07, 8'hFF};
        v_b    = '{8'h0F, 8'h3C, 8'h99, 8'h00, 8'h00};
        v_res  = '{8'h00, 8'hFF, 8'h01, 8'h07, 8'h00};
        v_flag = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = v_op[i];
            bus.R2       = v_a[i];
            bus.R3       = v_b[i];
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== v_res[i])
                $display("FAIL flags_result vec=%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.result, v_res[i]);
            else passed++;
            total++;
            if ({bus.flag_zero, bus.flag_ones, bus.flag_parity} !== v_flag[i])
                $display("FAIL flags_zop vec=%0d got=%b exp=%b", i,
                         {bus.flag_zero, bus.flag_ones, bus.flag_parity}, v_flag[i]);
            else passed++;
            $display("tx flags vec=%0d result=%h zop=%b", i, bus.result,
                     {bus.flag_zero, bus.flag_ones, bus.flag_parity});
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] v_op  [4];
        logic [7:0] v_res [4];
        int sent;
        int got;
        logic acc;
        logic take;
        v_op  = '{OP_AND, OP_OR, OP_XOR, OP_NOT};
        v_res = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
        // Pending output from the previous test drains while the counter clears.
        bus.in_valid = 1'b0;
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        total++;
        if (op_count !== 4'd0) $display("FAIL bp_clear_wins got=%0d exp=0", op_count);
        else passed++;
        bus.out_ready = 1'b0;
        bus.R2 = 8'hF0;
        bus.R3 = 8'h3C;
        bus.in_valid = 1'b1;
        bus.op = v_op[0];
        @(negedge clk);
        bus.op = v_op[1];
        #1;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_second_accept got=%b exp=1", bus.in_ready);
        else passed++;
        @(negedge clk);
        bus.op = v_op[2];
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h30 || op_count !== 4'd0)
                $display("FAIL bp_stall cyc=%0d got=rdy%b/v%b/%h/cnt%0d exp=rdy0/v1/30/cnt0",
                         k, bus.in_ready, bus.out_valid, bus.result, op_count);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        sent = 2;
        got  = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            #1;
            acc  = bus.in_valid & bus.in_ready;
            take = bus.out_valid & bus.out_ready;
            if (take) begin
                total++;
                if (bus.result !== v_res[got])
                    $display("FAIL bp_order idx=%0d got=%h exp=%h", got, bus.result, v_res[got]);
                else passed++;
                $display("tx bp idx=%0d result=%h", got, bus.result);
                got++;
            end
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 4) bus.op = v_op[sent];
                else bus.in_valid = 1'b0;
            end
        end
        total++;
        if (got !== 4 || sent !== 4) $display("FAIL bp_complete got=%0d/%0d exp=4/4", got, sent);
        else passed++;
        bus.in_valid = 1'b0;
        repeat (2) begin
            total++;
            if (bus.out_valid !== 1'b0) $display("FAIL bp_duplicate got=%b exp=0", bus.out_valid);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (op_count !== 4'd4) $display("FAIL bp_op_count got=%0d exp=4", op_count);
        else passed++;
    endtask

    task automatic test_counter();
        int ready_cnt;
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = OP_PASS;
        bus.R2 = 8'h11;
        bus.in_valid = 1'b1;
        ready_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (bus.in_ready === 1'b1) ready_cnt++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (ready_cnt !== 15) $display("FAIL cnt_throughput got=%0d exp=15", ready_cnt);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (op_count !== 4'd15) $display("FAIL cnt_fifteen got=%0d exp=15", op_count);
        else passed++;
        $display("tx counter after 15 ops=%0d", op_count);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (op_count !== 4'd15) $display("FAIL cnt_saturate got=%0d exp=15", op_count);
        else passed++;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL cnt_clr_hs_valid got=%b exp=1", bus.out_valid);
        else passed++;
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        total++;
        if (op_count !== 4'd0 || bus.out_valid !== 1'b0)
            $display("FAIL cnt_clr_wins got=%0d/v%b exp=0/v0", op_count, bus.out_valid);
        else passed++;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (op_count !== 4'd1) $display("FAIL cnt_restart got=%0d exp=1", op_count);
        else passed++;
        $display("tx counter after clear+1=%0d", op_count);
    endtask

    task automatic test_midreset();
        logic seen_valid;
        bus.in_valid = 1'b1;
        bus.op = OP_PASS;
        bus.R2 = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00)
            $display("FAIL mid_reset_outputs got=v%b/%h exp=v0/00", bus.out_valid, bus.result);
        else passed++;
        total++;
        if ({bus.flag_zero, bus.flag_ones, bus.flag_parity} !== 3'b000 || op_count !== 4'd0)
            $display("FAIL mid_reset_flags_count got=%b/%0d exp=000/0",
                     {bus.flag_zero, bus.flag_ones, bus.flag_parity}, op_count);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL mid_reset_in_ready got=%b exp=1", bus.in_ready);
        else passed++;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid !== 1'b0) $display("FAIL mid_reset_emitted got=1 exp=0");
        else passed++;
        $display("tx mid-op reset done");
    endtask

    initial begin
        test_reset();
        test_ops();
        test_flags();
        test_backpressure();
        test_counter();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined N-bit bitwise logic unit; successor to the 1-bit single-function NAND cell.
- Selects one of eight bitwise operations on register operands R2/R3 and produces zero/ones/parity flags.
- Two-stage valid/ready pipeline with full backpressure, plus a saturating completed-operation counter.
- Sits between the register file read ports and the ALU result mux.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- COUNT_W, 16, width of completed-operation counter (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept this cycle
- op  input  3  operation select (codes below)
- R2  input  WIDTH  operand A
- R3  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- flag_zero  output  1  result == 0
- flag_ones  output  1  result == all ones
- flag_parity  output  1  XOR-reduce of result
- count_clr  input  1  synchronous clear of op_count
- op_count  output  COUNT_W  completed operations, saturating

Behaviour:
- Op codes: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT R2 (R3 ignored), 111 PASS R2.
- Reset (rst_n=0 at a clk edge): every register cleared; out_valid=0, result=0, all flags=0, op_count=0, internal stage-A valid=0. in_ready is combinational and reads 1 during and after reset. Reset mid-operation discards all in-flight data; nothing is emitted.
- Stage A: registers R2, R3, op on an input handshake (in_valid & in_ready).
- Stage B: computes the op and flags from stage A; registers result, flags, out_valid.
- Handshake:
  - b_ready = !out_valid | out_ready.
  - a_ready = !a_valid | b_ready.
  - in_ready = a_ready. This is a combinational path from out_ready; accepted.
- Latency: input handshake at edge N → out_valid=1 after edge N+1. Throughput is 1 op/cycle with out_ready held high.
- Stall: while out_valid & !out_ready, result/flags/out_valid hold stable. Stage A holds if full. in_ready=0 only when both stages are full and out_ready=0. No data is dropped or duplicated.
- Simultaneous output handshake and input handshake in the same cycle: both stages advance; no bubble.
- in_valid with in_ready=0: inputs are ignored. The producer must hold them.
- Flags are registered alongside result and always consistent with it. With WIDTH=1: flag_zero = !result, flag_ones = result, flag_parity = result.
- op_count increments by 1 on each output handshake (out_valid & out_ready), saturating at 2^COUNT_W−1.
- count_clr=1 forces op_count to 0 at the next edge; clear wins over a simultaneous increment.
- op values are fully decoded; no X propagation for any 3-bit code.

Decomposition:
- Shared package/include logic_unit_defs: localparams OP_AND … OP_PASS (3-bit codes), OP_W=3.
- Sub-module logic_unit_core: purely combinational WIDTH-bit op select plus flag generation. It is instantiated in stage B. It generalises the 1-bit NAND cell to all eight ops.
- Pipeline control, registers and counter live in logic_unit_pipe.

Test Plan (WIDTH=8, COUNT_W=4):
- Reset then idle: rst_n=0 for 2 cycles → out_valid=0, result=8'h00, flags=0, op_count=0, in_ready=1.
- Per-op check: R2=8'hA5, R3=8'h0F, each op with out_ready=1 → results AND 05, NAND FA, OR AF, NOR 50, XOR AA, XNOR 55, NOT 5A, PASS A5. Each appears exactly 2 cycles after acceptance. For NAND FA: parity=0, zero=0, ones=0.
- Flags: AND with R2=8'hF0, R3=8'h0F → result 00, flag_zero=1. XNOR with equal operands → result FF, flag_ones=1, parity=0.
- Backpressure: stream 4 ops with out_ready=0 → in_ready drops after 2 accepted. Output is held stable. Release out_ready → remaining ops emerge in order with no loss or duplication. op_count=4.
- Counter: 15 handshakes → op_count=15. 3 more → stays 15. count_clr=1 asserted with a simultaneous handshake → op_count=0.
- Mid-op reset: accept an op, assert rst_n=0 next cycle → out_valid never rises for that op. All outputs are 0 after the reset edge.
